// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
//   Shared SHA-256 definitions used by the message-schedule and round stages:
//     - fixed widths (32-bit words, 16-word block, 64 rounds)
//     - the 64 round constants K[0..63]
//     - rotr / ssig0 / ssig1 helper functions
//     - the schedule FSM state type
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int ROUNDS    = 64;
    localparam int BLK_WORDS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam logic [WORD_W-1:0] SHA256_K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotate right. The left-shift amount (0 - n) mod 32 equals 32 - n for
    // n != 0 and degenerates harmlessly to x | x for n == 0.
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input logic [4:0]        n);
        return (x >> n) | (x << (5'd0 - n));
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// -----------------------------------------------------------------------------
// sha256_k_rom
//   Combinational round-constant lookup: K[idx].
//   Ports:
//     idx  in   6   round index 0..63
//     k    out  32  round constant K[idx]
// -----------------------------------------------------------------------------
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]        idx,
    output logic [WORD_W-1:0] k
);

    assign k = SHA256_K[idx];

endmodule

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//   Accepts one padded 512-bit block and streams W[0..63] with K[t] and t,
//   one word per downstream handshake, using a 16-word sliding window.
//   Ports:
//     clk        in   1    clock, rising edge
//     rst        in   1    asynchronous active-high reset
//     clear      in   1    synchronous abort back to IDLE
//     blk_valid  in   1    upstream block available
//     blk_ready  out  1    high in IDLE
//     blk_data   in   512  big-endian block, word 0 in [511:480]
//     w_valid    out  1    high in RUN
//     w_ready    in   1    downstream consumes on w_valid && w_ready
//     w_data     out  32   W[t]
//     k_data     out  32   K[t]
//     w_idx      out  6    t
//     w_last     out  1    w_valid && t == 63
// -----------------------------------------------------------------------------
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          blk_valid,
    output logic                          blk_ready,
    input  logic [BLK_WORDS*WORD_W-1:0]   blk_data,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic [WORD_W-1:0]             w_data,
    output logic [WORD_W-1:0]             k_data,
    output logic [5:0]                    w_idx,
    output logic                          w_last
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    sched_state_e      state_reg, state_next;
    logic [5:0]        t_reg, t_next;
    logic [WORD_W-1:0] win_reg  [0:BLK_WORDS-1];
    logic [WORD_W-1:0] win_next [0:BLK_WORDS-1];
    logic              load;
    logic              shift;
    logic [WORD_W-1:0] w_new;

    // W[t+16] from the current window (win[0] holds W[t]). Values produced
    // for t >= 48 are shifted in but never reach win[0] before the block ends.
    assign w_new = ssig1(win_reg[14]) + win_reg[9] + ssig0(win_reg[1]) + win_reg[0];

    // Control: clear overrides everything, including a pending block or
    // word handshake in the same cycle.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        load       = 1'b0;
        shift      = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            t_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (blk_valid) begin
                        load       = 1'b1;
                        t_next     = '0;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_ready) begin
                        shift = 1'b1;
                        if (t_reg == LAST_IDX) begin
                            state_next = ST_IDLE;
                            t_next     = '0;
                        end else begin
                            t_next = t_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    t_next     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    // Per-slot next value: load from the block, shift toward slot 0, or hold.
    genvar gi;
    generate
        for (gi = 0; gi < BLK_WORDS; gi++) begin : g_win
            logic [WORD_W-1:0] shift_in;
            if (gi == BLK_WORDS - 1) begin : g_top
                assign shift_in = w_new;
            end else begin : g_mid
                assign shift_in = win_reg[gi+1];
            end
            assign win_next[gi] = load  ? blk_data[(BLK_WORDS-1-gi)*WORD_W +: WORD_W] :
                                  shift ? shift_in : win_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            win_reg <= win_next;
        end
    end

    sha256_k_rom u_k_rom (
        .idx (t_reg),
        .k   (k_data)
    );

    // All outputs come straight from registers; w_ready never reaches them.
    assign blk_ready = (state_reg == ST_IDLE);
    assign w_valid   = (state_reg == ST_RUN);
    assign w_data    = win_reg[0];
    assign w_idx     = t_reg;
    assign w_last    = (state_reg == ST_RUN) && (t_reg == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [31:0]  k_data;
    logic [5:0]   w_idx;
    logic         w_last;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .k_data    (k_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] tk    [64];
    logic [31:0] mw    [64];
    logic [31:0] mwb   [64];
    logic [31:0] got_w [64];
    logic [31:0] got_k [64];

    typedef struct {
        int          idx;
        logic [31:0] w;
        logic [31:0] k;
    } vec_t;
    vec_t abc_tab [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: textbook recurrence over a full 64-entry array.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                mw[t] = blk[511 - 32*t -: 32];
            end else begin
                s0 = rr(mw[t-15], 7) ^ rr(mw[t-15], 18) ^ (mw[t-15] >> 3);
                s1 = rr(mw[t-2], 17) ^ rr(mw[t-2], 19) ^ (mw[t-2] >> 10);
                mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic send_block(input logic [511:0] blk);
        bit acc;
        model(blk);
        acc = 0;
        blk_valid = 1'b1;
        blk_data  = blk;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = blk_ready;
            tick();
        end
        blk_valid = 1'b0;
        chk("accept", acc, 1);
        chk("first_word_latency", {w_valid, blk_ready, w_idx}, {1'b1, 1'b0, 6'd0});
    endtask

    // mode 0: always ready; 1: random ready; 2: random plus 10-cycle stall at t=15
    task automatic collect(input int mode);
        int  cnt;
        int  stall;
        bit  hs;
        cnt   = 0;
        stall = 0;
        for (int n = 0; n < 1000 && cnt < 64; n++) begin
            if (mode == 0) w_ready = 1'b1;
            else if (mode == 2 && cnt == 15 && stall < 10) begin
                w_ready = 1'b0;
                stall++;
            end else w_ready = 1'($urandom_range(0, 1));
            chk("w_valid_run", {w_valid, blk_ready}, 2'b10);
            chk($sformatf("word_t%0d", cnt), {w_idx, w_data, k_data, w_last},
                {6'(cnt), mw[cnt], tk[cnt], (cnt == 63)});
            hs = w_valid && w_ready;
            if (hs) begin
                got_w[cnt] = w_data;
                got_k[cnt] = k_data;
            end
            tick();
            if (hs) cnt++;
        end
        w_ready = 1'b0;
        chk("stream_done", cnt, 64);
        chk("idle_after_last", {blk_ready, w_valid, w_last}, 3'b100);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_a, blk_b;
        int acc, nwords, cyc0, cyc1;
        bit hb, hw;
        logic [31:0] cw;
        logic [5:0]  ci;

        tk = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        abc_tab[0] = '{0,  32'h61626380, 32'h428a2f98};
        abc_tab[1] = '{1,  32'h00000000, 32'h71374491};
        abc_tab[2] = '{14, 32'h00000000, 32'h9bdc06a7};
        abc_tab[3] = '{15, 32'h00000018, 32'hc19bf174};
        abc_tab[4] = '{16, 32'h61626380, 32'he49b69c1};
        abc_tab[5] = '{17, 32'h000f0000, 32'hefbe4786};
        abc = {32'h61626380, 448'h0, 32'h00000018};

        // Reset values, during and after reset
        rst = 1'b1; clear = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; blk_data = '0;
        repeat (3) tick();
        chk("reset_during", {blk_ready, w_valid, w_data, k_data, w_idx, w_last},
            {1'b1, 1'b0, 32'h0, 32'h428a2f98, 6'd0, 1'b0});
        rst = 1'b0;
        tick();
        chk("reset_after", {blk_ready, w_valid, w_data, k_data, w_idx, w_last},
            {1'b1, 1'b0, 32'h0, 32'h428a2f98, 6'd0, 1'b0});

        // "abc" block, no backpressure, then table vectors
        send_block(abc);
        collect(0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("abc_tab_t%0d", abc_tab[i].idx),
                {got_w[abc_tab[i].idx], got_k[abc_tab[i].idx]}, {abc_tab[i].w, abc_tab[i].k});
        end
        chk("abc_K63", got_k[63], 32'hc67178f2);

        // Backpressure with a 10-cycle stall at t=15
        send_block(abc);
        collect(2);

        // clear at t=30 with w_ready high
        send_block(abc);
        w_ready = 1'b1;
        repeat (30) tick();
        chk("pre_clear_idx", {w_valid, w_idx}, {1'b1, 6'd30});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        w_ready = 1'b0;
        chk("after_clear", {w_valid, blk_ready, w_idx, w_last}, {1'b0, 1'b1, 6'd0, 1'b0});
        // clear in IDLE blocks a simultaneous blk_valid
        blk_valid = 1'b1; blk_data = abc; clear = 1'b1;
        tick();
        blk_valid = 1'b0; clear = 1'b0;
        chk("clear_blocks_accept", {w_valid, blk_ready}, 2'b01);
        send_block(abc);
        collect(0);

        // Asynchronous reset mid-RUN
        send_block(rand_blk());
        w_ready = 1'b1;
        repeat (21) tick();
        chk("pre_reset_idx", w_idx, 6'd21);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {w_valid, blk_ready, w_idx, w_last, w_data}, {1'b0, 1'b1, 6'd0, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        w_ready = 1'b0;
        tick();
        chk("post_reset_idle", {w_valid, blk_ready, w_idx}, {1'b0, 1'b1, 6'd0});
        send_block(rand_blk());
        collect(1);

        // Back-to-back: blk_valid held high across two blocks
        blk_a = rand_blk();
        blk_b = rand_blk();
        model(blk_b);
        mwb = mw;
        model(blk_a);
        acc = 0; nwords = 0; cyc0 = 0; cyc1 = 0;
        blk_valid = 1'b1; blk_data = blk_a; w_ready = 1'b1;
        for (int n = 0; n < 400 && nwords < 128; n++) begin
            hb = blk_valid && blk_ready;
            hw = w_valid && w_ready;
            cw = w_data;
            ci = w_idx;
            tick();
            if (hb) begin
                if (acc == 0) begin cyc0 = n; blk_data = blk_b; end
                else begin cyc1 = n; blk_valid = 1'b0; end
                acc++;
            end
            if (hw) begin
                chk($sformatf("b2b_word%0d", nwords), {ci, cw},
                    {6'(nwords % 64), (nwords < 64) ? mw[nwords] : mwb[nwords-64]});
                nwords++;
            end
        end
        blk_valid = 1'b0; w_ready = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_spacing", cyc1 - cyc0, 65);
        chk("b2b_words", nwords, 128);
        chk("b2b_idle", {blk_ready, w_valid}, 2'b10);

        // 100 random blocks with random backpressure
        for (int b = 0; b < 100; b++) begin
            send_block(rand_blk());
            collect(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule stage directly upstream of the combinational sha256_round datapath.
- Accepts one 512-bit padded message block over a valid/ready handshake.
- Streams the 64 schedule words W[0..63], each paired with its round constant K[t] and round index, one word per accepted cycle.
- Uses a 16-word sliding window, so no 64-word storage is needed.

Parameters:
- None. SHA-256 widths are fixed: 32-bit words, 16-word block, 64 rounds.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort: return to IDLE and drop the current block
- blk_valid  in  1  upstream has a block
- blk_ready  out  1  block accepted when blk_valid && blk_ready
- blk_data  in  512  padded block, big-endian; word 0 = bits [511:480], word 15 = bits [31:0]
- w_valid  out  1  w_data/k_data/w_idx are valid
- w_ready  in  1  downstream (round controller) consumes on w_valid && w_ready
- w_data  out  32  W[t]
- k_data  out  32  K[t]
- w_idx  out  6  t, 0..63
- w_last  out  1  high when w_idx == 63 and w_valid

Behaviour:
- Reset (async, rst=1): state=IDLE, t=0, all window registers 0.
  - Outputs during/after reset: blk_ready=1, w_valid=0, w_data=0, k_data=K[0], w_idx=0, w_last=0.
- States: IDLE, RUN.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid (and clear=0): win[i] <= blk_data word i for i=0..15; t <= 0; next state RUN.
- RUN:
  - blk_ready=0, w_valid=1.
  - w_data=win[0], k_data=K[t], w_idx=t, all registered/direct from state, with no combinational path from w_ready to any output.
  - On w_valid && w_ready:
    - win[i] <= win[i+1] for i=0..14.
    - win[15] <= ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], mod 2^32. This produces W[t+16].
    - t <= t+1.
  - If t==63 at the handshake: next state IDLE, t <= 0. win[15] values computed for t>=48 are don't-care (never presented).
  - w_ready=0: hold all state and outputs unchanged, for any number of cycles.
- Latency: first word presented the cycle after block acceptance.
  - Minimum block period is 65 cycles (64 RUN + 1 IDLE).
  - blk_ready is never high in RUN; no back-to-back overlap.
- Schedule functions:
  - ssig0(x) = rotr7 ^ rotr18 ^ shr3.
  - ssig1(x) = rotr17 ^ rotr19 ^ shr10.
- clear:
  - Highest priority after rst; takes effect at the next edge from any state.
  - Results: t=0, IDLE, w_valid=0.
  - A simultaneous blk_valid is not accepted.
  - A handshake in the same cycle as clear is discarded.
- Reset mid-RUN: immediate return to the reset values above; the partial block is lost and no further words are emitted.
- w_idx wraps 63 -> 0 only via the return to IDLE; t never exceeds 63.

Decomposition:
- Shared package sha256_pkg holds:
  - SHA256_K[0:63] constant array, WORD_W=32, ROUNDS=64.
  - Functions rotr, ssig0, ssig1, shared with the round stage.
- One natural sub-module: sha256_k_rom, a combinational 6-bit index -> 32-bit K lookup built from SHA256_K.
- The window shift register and FSM stay in the top module.

Test Plan:
- Reset and idle check:
  - Stimulus: assert rst mid-RUN (after t=20).
  - Required: immediately w_valid=0, blk_ready=1, w_idx=0; next block restarts at t=0.
- "abc" block: blk_data = 0x61626380, 14x 0x00000000, 0x00000018; w_ready held 1.
  - W0=0x61626380, W1..W15=0 except W15=0x00000018.
  - W16=0x61626380, W17=0x000F0000.
  - K0=0x428a2f98, K63=0xc67178f2.
  - w_last only on w_idx=63; blk_ready returns 1 on the following cycle.
- Backpressure:
  - Stimulus: same block, w_ready toggled randomly (incl. 10-cycle stall at t=15).
  - Required: word sequence identical to the no-stall run; outputs stable while stalled.
- clear:
  - Stimulus: pulse clear at t=30 while w_ready=1.
  - Required: next cycle w_valid=0, IDLE; a new block then streams from W0 with correct W16/W17.
- Back-to-back:
  - Stimulus: blk_valid held high with two blocks.
  - Required: second block accepted exactly on the IDLE cycle after first w_last handshake; 65-cycle spacing; no word loss or duplication.
- Random blocks:
  - Stimulus: 100 random 512-bit blocks.
  - Required: all 64 words per block match a reference-model schedule.
